// File: rtl/vec3_normalize.sv
// Multi-cycle vec3 normalizer: squared length, bitwise sqrt, restoring reciprocal, then per-component scale.
// One vector in flight; valid/ready on input and output.
module vec3_normalize #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FRACT      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3*DATA_WIDTH-1:0]   in_vec,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [3*DATA_WIDTH-1:0]   out_vec,
    output logic                      out_zero,
    output logic                      out_sat
);
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
    localparam logic [DW:0] DIVIDEND = (DW+1)'(1) << (2 * FRACT);
    localparam logic [DW-1:0] RMAX = {1'b0, {(DW-1){1'b1}}};

    typedef enum logic [2:0] {IDLE, SQSUM, SQRT, RECIP, SCALE, DONE} state_t;

    state_t               state, state_nx;
    logic [CW-1:0]        cnt;
    logic signed [DW-1:0] vx, vy, vz;
    logic [PW-1:0]        l2;
    logic [DW-1:0]        srem, root;
    logic [DW-1:0]        drem;
    logic [DW:0]          dvd, quo;

    logic                 acc;
    logic [PW-1:0]        l2_sum;
    logic [DW+1:0]        srem_sh, trial;
    logic                 s_ge;
    logic [DW:0]          drem_sh;
    logic                 d_ge;
    logic                 r_zero, r_sat;
    logic [DW-1:0]        rsel;

    // (c * r) >>> FRACT on the full-width signed product, low DW bits kept
    function automatic logic [DW-1:0] scale_c(input logic signed [DW-1:0] c,
                                              input logic signed [DW-1:0] r);
        logic signed [PW-1:0] p;
        p = c * r;
        p = p >>> FRACT;
        return p[DW-1:0];
    endfunction

    assign acc = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (acc) state_nx = SQSUM;
            SQSUM:   state_nx = SQRT;
            SQRT:    if (cnt == CW'(DW - 1)) state_nx = RECIP;
            RECIP:   if (cnt == CW'(DW)) state_nx = SCALE;
            SCALE:   state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath step values for the current state
    always_comb begin
        logic signed [PW-1:0] sx, sy, sz;
        sx      = vx * vx;
        sy      = vy * vy;
        sz      = vz * vz;
        l2_sum  = $unsigned(sx) + $unsigned(sy) + $unsigned(sz);
        srem_sh = {srem, l2[PW-1:PW-2]};
        trial   = {root, 2'b01};
        s_ge    = (srem_sh >= trial);
        drem_sh = {drem, dvd[DW]};
        d_ge    = (drem_sh >= {1'b0, root});
        r_zero  = (root == '0);
        r_sat   = !r_zero && (quo[DW:DW-1] != 2'b00);
        rsel    = r_zero ? '0 : (r_sat ? RMAX : quo[DW-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_vec   <= '0;
            out_zero  <= 1'b0;
            out_sat   <= 1'b0;
            cnt       <= '0;
            vx        <= '0;
            vy        <= '0;
            vz        <= '0;
            l2        <= '0;
            srem      <= '0;
            root      <= '0;
            drem      <= '0;
            dvd       <= '0;
            quo       <= '0;
        end else begin
            in_ready  <= (state_nx == IDLE);
            out_valid <= (state_nx == DONE);
            case (state)
                IDLE: if (acc) begin
                    vx       <= in_vec[3*DW-1:2*DW];
                    vy       <= in_vec[2*DW-1:DW];
                    vz       <= in_vec[DW-1:0];
                    out_zero <= 1'b0;
                    out_sat  <= 1'b0;
                end
                SQSUM: begin
                    l2   <= l2_sum;
                    srem <= '0;
                    root <= '0;
                    drem <= '0;
                    dvd  <= DIVIDEND;
                    quo  <= '0;
                    cnt  <= '0;
                end
                SQRT: begin
                    l2   <= l2 << 2;
                    srem <= DW'(s_ge ? (srem_sh - trial) : srem_sh);
                    root <= {root[DW-2:0], s_ge};
                    cnt  <= (cnt == CW'(DW - 1)) ? '0 : cnt + 1'b1;
                end
                RECIP: begin
                    drem <= DW'(d_ge ? (drem_sh - {1'b0, root}) : drem_sh);
                    quo  <= {quo[DW-1:0], d_ge};
                    dvd  <= dvd << 1;
                    cnt  <= cnt + 1'b1;
                end
                SCALE: begin
                    out_vec  <= {scale_c(vx, rsel), scale_c(vy, rsel), scale_c(vz, rsel)};
                    out_zero <= r_zero;
                    out_sat  <= r_sat;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vec3_normalize.sv
// Directed bench for vec3_normalize: vector table with hand-computed results, plus
// backpressure and mid-operation reset sequences.
module tb_vec3_normalize;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [95:0] out_vec;
    logic        out_zero;
    logic        out_sat;

    int checks = 0;
    int errors = 0;

    vec3_normalize #(.DATA_WIDTH(32), .FRACT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
        .out_zero(out_zero), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] x, y, z;
        logic [31:0] ex, ey, ez;
        logic        ezero, esat;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present a vector and complete the input handshake; leaves time at handshake edge + 1
    task automatic send(input string nm, input logic [95:0] v);
        int n = 0;
        in_vec   = v;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk({nm, " in_ready"}, 96'(in_ready), 96'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({nm, " flags cleared"}, 96'({out_zero, out_sat, out_valid, in_ready}), 96'(0));
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic release_out(input string nm);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, " out_valid drop"}, 96'(out_valid), 96'(0));
    endtask

    initial begin
        int          lat;
        logic [95:0] held;

        tbl[0] = '{"v345",   32'h00030000, 32'h00040000, 32'h0, 32'h00009999, 32'h0000CCCC, 32'h0, 1'b0, 1'b0};
        tbl[1] = '{"negx",   32'hFFFF0000, 32'h0, 32'h0, 32'hFFFF0000, 32'h0, 32'h0, 1'b0, 1'b0};
        tbl[2] = '{"zero",   32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0};
        tbl[3] = '{"tiny1",  32'h00000001, 32'h0, 32'h0, 32'h00007FFF, 32'h0, 32'h0, 1'b0, 1'b1};
        tbl[4] = '{"unitz",  32'h0, 32'h0, 32'h00010000, 32'h0, 32'h0, 32'h00010000, 1'b0, 1'b0};
        tbl[5] = '{"neg34",  32'h0, 32'hFFFD0000, 32'h00040000, 32'h0, 32'hFFFF6667, 32'h0000CCCC, 1'b0, 1'b0};
        tbl[6] = '{"two",    32'h00020000, 32'h0, 32'h0, 32'h00010000, 32'h0, 32'h0, 1'b0, 1'b0};
        tbl[7] = '{"small",  32'h00000100, 32'h0, 32'h0, 32'h00010000, 32'h0, 32'h0, 1'b0, 1'b0};
        tbl[8] = '{"neg1sat",32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFF8000, 32'h0, 32'h0, 1'b0, 1'b1};
        tbl[9] = '{"len2sat",32'h00000002, 32'h0, 32'h0, 32'h0000FFFF, 32'h0, 32'h0, 1'b0, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
        #12;
        chk("reset outputs", {out_vec[91:0], in_ready, out_valid, out_zero, out_sat}, 96'b1000);
        chk("reset vec", out_vec, 96'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            send(tbl[i].nm, {tbl[i].x, tbl[i].y, tbl[i].z});
            wait_out(lat);
            chk({tbl[i].nm, " latency"}, 96'(lat), 96'(67));
            chk({tbl[i].nm, " vec"}, out_vec, {tbl[i].ex, tbl[i].ey, tbl[i].ez});
            chk({tbl[i].nm, " flags"}, 96'({out_zero, out_sat}), 96'({tbl[i].ezero, tbl[i].esat}));
            release_out(tbl[i].nm);
        end

        // len=3 just below the saturation boundary
        send("len3", {32'h3, 32'h0, 32'h0});
        wait_out(lat);
        chk("len3 vec", out_vec, {32'h0000FFFF, 32'h0, 32'h0});
        chk("len3 flags", 96'({out_zero, out_sat}), 96'(0));
        release_out("len3");

        // Backpressure: result held, new input ignored while DONE waits
        send("bp", {32'h00030000, 32'h00040000, 32'h0});
        wait_out(lat);
        held     = out_vec;
        chk("bp vec", held, {32'h00009999, 32'h0000CCCC, 32'h0});
        in_vec   = {32'h1, 32'h0, 32'h0};
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("bp hold", {out_vec[93:0], out_valid, in_ready}, {held[93:0], 2'b10});
            chk("bp flags", 96'({out_zero, out_sat}), 96'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp drop", 96'({out_valid, in_ready}), 96'b01);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp no bypass", 96'({out_valid, in_ready}), 96'b01);

        // Reset pulsed during SQRT aborts the vector
        send("rst", {32'h00030000, 32'h00040000, 32'h0});
        repeat (10) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #2;
        chk("mid reset outs", 96'({in_ready, out_valid, out_zero, out_sat}), 96'b1000);
        chk("mid reset vec", out_vec, 96'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (70) begin
            @(posedge clk); #1;
            if (out_valid) break;
        end
        chk("mid reset no output", 96'(out_valid), 96'(0));
        send("after rst", {32'h0, 32'hFFFD0000, 32'h00040000});
        wait_out(lat);
        chk("after rst latency", 96'(lat), 96'(67));
        chk("after rst vec", out_vec, {32'h0, 32'hFFFF6667, 32'h0000CCCC});
        release_out("after rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
